fx2_regbank_sync: RTL and testbench
===================================

# fx2_regbank_sync

Parametrised, fully synchronous register bank behind the FX2 16-bit multiplexed address/data strobe bus. It is the next generation of the FX2 register interface: every strobe is synchronised into the system clock, and the block provides per-register write pulses, read-only register windows with read pulses, and optional address auto-increment for burst transfers. It sits between the top-level FX2 pins and the generator core (control/mode/amplitude/offset/config registers, waveform-memory data port, ADC readback). The tri-state pad stays in the top level.

## Interface
- `DATA_W`, 16, bus and register width.
- `ADDR_W`, 5, address bits latched from `fx2_data_i[ADDR_W-1:0]` on the address strobe.
- `NUM_RW`, 16, number of read/write registers at addresses 0..NUM_RW-1.
- `NUM_RO`, 4, number of read-only registers at addresses NUM_RW..NUM_RW+NUM_RO-1. NUM_RW+NUM_RO ≤ 2^ADDR_W.
- `AUTO_INC`, 0, when 1 the address increments after every data cycle.
- `RESET_VALS`, all zero, NUM_RW*DATA_W flat vector of register reset values; register i uses bits [i*DATA_W +: DATA_W].

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fx2_data_i`  in  DATA_W  bus value from the pad.
- `fx2_data_o`  out  DATA_W  read data to the pad.
- `fx2_data_oe`  out  1  pad output enable.
- `fx2_as`  in  1  address strobe; asynchronous to `clk`.
- `fx2_ds`  in  1  data strobe; asynchronous to `clk`.
- `fx2_nrdwr`  in  1  0 = read, 1 = write.
- `rw_regs`  out  NUM_RW*DATA_W  flat read/write register contents.
- `ro_regs`  in  NUM_RO*DATA_W  flat read-only sources, for example the ADC result.
- `wr_pulse`  out  NUM_RW  one-cycle pulse per register on write; replaces the old waveform-memory clock.
- `rd_pulse`  out  NUM_RO  one-cycle pulse per read-only register on read, for FIFO pop.
- `err`  out  1  sticky flag: write to a read-only or unmapped address. Cleared only by reset.

## Operation
- **Synchronisers.**
  - `fx2_as`, `fx2_ds` and `fx2_nrdwr` pass through 2-FF synchronisers.
  - `fx2_data_i` is registered through an equal-depth pipeline so that data stays aligned with the strobes.
  - A rising or falling edge is detected from the 2nd and 3rd stage.
- **AS rising edge.** `addr` ← aligned data[ADDR_W-1:0].
- **DS rising edge, write** (nrdwr = 1).
  - addr < NUM_RW: register[addr] ← aligned data, and `wr_pulse[addr]` is high in the same cycle as the update.
  - Otherwise: the write is ignored and `err` is set.
- **DS rising edge, read** (nrdwr = 0).
  - `fx2_data_o` ← register[addr] if addr < NUM_RW.
  - `fx2_data_o` ← ro_regs[addr-NUM_RW] if addr is inside the read-only window; `rd_pulse` fires for that register.
  - Otherwise `fx2_data_o` ← 0.
  - `fx2_data_oe` ← 1.
- **DS falling edge.**
  - `fx2_data_oe` ← 0.
  - If AUTO_INC = 1, `addr` ← addr+1 modulo 2^ADDR_W (wraps from 2^ADDR_W-1 to 0).
- **Simultaneous events.**
  - AS and DS rising edges in the same cycle: the address is updated first, and the data cycle uses the new address.
  - AS rising edge together with a DS falling edge: the AS load wins over the increment.
- **`fx2_data_o` is held** for the whole read cycle. It does not follow changes on `ro_regs` after it is sampled.
- **Reset** (asynchronous, including mid-transfer):
  - `rw_regs` = RESET_VALS.
  - addr = 0; `fx2_data_o` = 0; `fx2_data_oe` = 0; `wr_pulse`, `rd_pulse` and `err` = 0.
  - Synchroniser stages = 0, so no spurious edge is seen after reset.
  - An in-flight strobe that is already high at release is not treated as an edge.

## Timing
- Strobe edge at the pin → action at clk edge 3 (2 synchroniser stages + 1 edge register).
- Write-register update and `wr_pulse`: 3 cycles after the DS rising edge. The pulse is exactly 1 cycle wide.
- Read data and `fx2_data_oe` valid: 3 cycles after the DS rising edge. The FX2 must hold DS high for ≥ 5 clk before sampling.
- Minimum strobe high and low time is 3 clk. Data must be stable from 1 clk before the strobe rises until 3 clk after it.
- `fx2_data_oe` drops 3 cycles after the DS falling edge. The host must not drive the bus within 4 clk of releasing DS on a read.

## Structure
- **Package `fx2_bus_pkg`:**
  - `DATA_W` and `ADDR_W` defaults.
  - Register index constants: CTRL=0, MODE=1, AMPL=2, OFFS=3, CONF1_L/H=4/5, CONF2_L/H=6/7, CONF3_L/H=8/9, WF_DATA=10, ADC=16.
- **Sub-module `sync_edge`:** 2-FF synchroniser plus rise/fall detect. It is instantiated for AS and DS; the nrdwr path uses the same module with the edge outputs unused.

## Test plan
- Reset with RESET_VALS[1] = 16'h6700 → `rw_regs` reg 1 = 16'h6700, all others 0, `fx2_data_oe` = 0, `err` = 0.
- AS with data 10, then write DS with 16'hA5A5 → reg 10 = 16'hA5A5 at cycle 3; `wr_pulse[10]` high for exactly 1 cycle.
- AS with 16, read DS, `ro_regs[0]` = 16'h1234 → `fx2_data_o` = 16'h1234, oe = 1, `rd_pulse[0]` fires once; address 25 reads 0.
- Write to address 17 → no register changes, `err` = 1 and stays set through subsequent valid writes.
- AUTO_INC = 1: AS = 30, then 4 writes → data lands at 30 and 31 (both ignored, `err` set), then at 0 and 1 (stored), confirming the wrap.
- Assert `rst_n` low while DS is high during a read → oe = 0 immediately. After release with DS still high, no read and no `rd_pulse` occur.

Source files
------------

// File: rtl/fx2_bus_pkg.sv
// Shared constants for the FX2 strobe-bus register bank: default widths,
// synchroniser priming length and the generator-core register map.
package fx2_bus_pkg;

    localparam int FX2_DATA_W = 16;
    localparam int FX2_ADDR_W = 5;

    // Cycles after reset before edge detection is trusted: two synchroniser
    // stages plus the edge register must all hold live pin samples.
    localparam int PRIME_CYCLES = 3;

    localparam int REG_CTRL    = 0;
    localparam int REG_MODE    = 1;
    localparam int REG_AMPL    = 2;
    localparam int REG_OFFS    = 3;
    localparam int REG_CONF1_L = 4;
    localparam int REG_CONF1_H = 5;
    localparam int REG_CONF2_L = 6;
    localparam int REG_CONF2_H = 7;
    localparam int REG_CONF3_L = 8;
    localparam int REG_CONF3_H = 9;
    localparam int REG_WF_DATA = 10;
    localparam int REG_ADC     = 16;

endpackage

// File: rtl/fx2_regbank_sync_edge.sv
// 2-FF synchroniser for one asynchronous FX2 strobe, with rise/fall detection
// from the second and third stages.
module sync_edge
    import fx2_bus_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic                    s1_q, s2_q, s3_q;
    logic [PRIME_CYCLES-1:0] prime_q;

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the value its predecessor held before this clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            prime_q <= '0;
        end else begin
            s1_q    <= async_i;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            prime_q <= {prime_q[PRIME_CYCLES-2:0], 1'b1};
        end
    end

    // Edges are masked until the pipeline holds real samples, so a strobe
    // already high when reset is released is not mistaken for a new edge.
    assign level_o = s2_q;
    assign rise_o  = prime_q[PRIME_CYCLES-1] &  s2_q & ~s3_q;
    assign fall_o  = prime_q[PRIME_CYCLES-1] & ~s2_q &  s3_q;

endmodule

// File: rtl/fx2_regbank_sync.sv
// FX2 multiplexed address/data register bank with all strobes synchronised
// into clk: read/write registers, read-only windows, write/read pulses.
module fx2_regbank_sync
    import fx2_bus_pkg::*;
#(
    parameter int DATA_W   = FX2_DATA_W,
    parameter int ADDR_W   = FX2_ADDR_W,
    parameter int NUM_RW   = 16,
    parameter int NUM_RO   = 4,
    parameter int AUTO_INC = 0,
    parameter logic [NUM_RW*DATA_W-1:0] RESET_VALS = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        fx2_data_i,
    output logic [DATA_W-1:0]        fx2_data_o,
    output logic                     fx2_data_oe,
    input  logic                     fx2_as,
    input  logic                     fx2_ds,
    input  logic                     fx2_nrdwr,
    output logic [NUM_RW*DATA_W-1:0] rw_regs,
    input  logic [NUM_RO*DATA_W-1:0] ro_regs,
    output logic [NUM_RW-1:0]        wr_pulse,
    output logic [NUM_RO-1:0]        rd_pulse,
    output logic                     err
);

    logic as_rise, as_level_unused, as_fall_unused;
    logic ds_rise, ds_fall, ds_level_unused;
    logic nrdwr_s, nrdwr_rise_unused, nrdwr_fall_unused;

    sync_edge u_as (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (fx2_as),
        .level_o (as_level_unused),
        .rise_o  (as_rise),
        .fall_o  (as_fall_unused)
    );

    sync_edge u_ds (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (fx2_ds),
        .level_o (ds_level_unused),
        .rise_o  (ds_rise),
        .fall_o  (ds_fall)
    );

    sync_edge u_nrdwr (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (fx2_nrdwr),
        .level_o (nrdwr_s),
        .rise_o  (nrdwr_rise_unused),
        .fall_o  (nrdwr_fall_unused)
    );

    logic [DATA_W-1:0]        data_s1_q, data_s2_q;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [NUM_RW*DATA_W-1:0] rw_q, rw_d;
    logic [DATA_W-1:0]        data_o_q, data_o_d;
    logic                     oe_q, oe_d;
    logic [NUM_RW-1:0]        wr_pulse_q, wr_pulse_d;
    logic [NUM_RO-1:0]        rd_pulse_q, rd_pulse_d;
    logic                     err_q, err_d;

    logic [ADDR_W-1:0]        cur_addr;
    logic [NUM_RW-1:0]        wr_sel;
    logic [NUM_RO-1:0]        rd_sel;
    logic [DATA_W-1:0]        rd_data;

    // Address decode; an AS edge in the same cycle as DS supplies the address.
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        cur_addr = as_rise ? data_s2_q[ADDR_W-1:0] : addr_q;
        wr_sel   = '0;
        rd_sel   = '0;
        rd_data  = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            if (cur_addr == ADDR_W'(i)) begin
                wr_sel[i] = 1'b1;
                rd_data   = rw_q[i*DATA_W +: DATA_W];
            end
        end
        for (int j = 0; j < NUM_RO; j++) begin
            if (cur_addr == ADDR_W'(NUM_RW + j)) begin
                rd_sel[j] = 1'b1;
                rd_data   = ro_regs[j*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        addr_d     = addr_q;
        rw_d       = rw_q;
        data_o_d   = data_o_q;
        oe_d       = oe_q;
        wr_pulse_d = '0;
        rd_pulse_d = '0;
        err_d      = err_q;

        // AS load takes priority over the post-cycle increment.
        if (as_rise) begin
            addr_d = data_s2_q[ADDR_W-1:0];
        end else if (AUTO_INC != 0 && ds_fall) begin
            addr_d = addr_q + 1'b1;
        end

        if (ds_rise && nrdwr_s) begin
            wr_pulse_d = wr_sel;
            if (wr_sel == '0) begin
                err_d = 1'b1;
            end
            for (int i = 0; i < NUM_RW; i++) begin
                if (wr_sel[i]) begin
                    rw_d[i*DATA_W +: DATA_W] = data_s2_q;
                end
            end
        end else if (ds_rise) begin
            data_o_d   = rd_data;
            oe_d       = 1'b1;
            rd_pulse_d = rd_sel;
        end else if (ds_fall) begin
            oe_d = 1'b0;
        end
    end

    // NOTE: the register bank is flops, not a RAM, so it takes its
    // per-register reset value directly from RESET_VALS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_s1_q  <= '0;
            data_s2_q  <= '0;
            addr_q     <= '0;
            rw_q       <= RESET_VALS;
            data_o_q   <= '0;
            oe_q       <= 1'b0;
            wr_pulse_q <= '0;
            rd_pulse_q <= '0;
            err_q      <= 1'b0;
        end else begin
            data_s1_q  <= fx2_data_i;
            data_s2_q  <= data_s1_q;
            addr_q     <= addr_d;
            rw_q       <= rw_d;
            data_o_q   <= data_o_d;
            oe_q       <= oe_d;
            wr_pulse_q <= wr_pulse_d;
            rd_pulse_q <= rd_pulse_d;
            err_q      <= err_d;
        end
    end

    assign fx2_data_o  = data_o_q;
    assign fx2_data_oe = oe_q;
    assign rw_regs     = rw_q;
    assign wr_pulse    = wr_pulse_q;
    assign rd_pulse    = rd_pulse_q;
    assign err         = err_q;

endmodule

// File: tb/tb_fx2_regbank_sync.sv
// Scoreboard bench for fx2_regbank_sync: one bank without and one with
// address auto-increment, driven by directed FX2 bus cycles.
module tb_fx2_regbank_sync;
    import fx2_bus_pkg::*;

    localparam int DW  = 16;
    localparam int AW  = 5;
    localparam int NRW = 16;
    localparam int NRO = 4;
    localparam logic [NRW*DW-1:0] RV0 = {{(NRW-2){16'h0000}}, 16'h6700, 16'h0000};

    typedef struct {
        int          dut;
        bit          is_rd;
        int          idx;
        logic [15:0] data;
        logic [3:0]  rd_mask;
    } exp_t;

    logic clk;
    logic rst_n;

    logic [DW-1:0]     data_i_a [2];
    logic [DW-1:0]     data_o_a [2];
    logic              oe_a     [2];
    logic              as_a     [2];
    logic              ds_a     [2];
    logic              nrdwr_a  [2];
    logic [NRW*DW-1:0] rw_a     [2];
    logic [NRO*DW-1:0] ro_a     [2];
    logic [NRW-1:0]    wr_a     [2];
    logic [NRO-1:0]    rd_a     [2];
    logic              err_a    [2];

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    fx2_regbank_sync #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_RW(NRW), .NUM_RO(NRO),
        .AUTO_INC(0), .RESET_VALS(RV0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n),
        .fx2_data_i(data_i_a[0]), .fx2_data_o(data_o_a[0]), .fx2_data_oe(oe_a[0]),
        .fx2_as(as_a[0]), .fx2_ds(ds_a[0]), .fx2_nrdwr(nrdwr_a[0]),
        .rw_regs(rw_a[0]), .ro_regs(ro_a[0]),
        .wr_pulse(wr_a[0]), .rd_pulse(rd_a[0]), .err(err_a[0])
    );

    fx2_regbank_sync #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_RW(NRW), .NUM_RO(NRO),
        .AUTO_INC(1), .RESET_VALS('0)
    ) dut1 (
        .clk(clk), .rst_n(rst_n),
        .fx2_data_i(data_i_a[1]), .fx2_data_o(data_o_a[1]), .fx2_data_oe(oe_a[1]),
        .fx2_as(as_a[1]), .fx2_ds(ds_a[1]), .fx2_nrdwr(nrdwr_a[1]),
        .rw_regs(rw_a[1]), .ro_regs(ro_a[1]),
        .wr_pulse(wr_a[1]), .rd_pulse(rd_a[1]), .err(err_a[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reg(input int s, input int i, input logic [15:0] exp);
        check($sformatf("dut%0d_reg%0d", s, i), 32'(rw_a[s][i*DW +: DW]), 32'(exp));
    endtask

    // Monitor: every write pulse and every rising output enable pops one entry.
    logic [NRW-1:0] wr_prev [2];
    logic           oe_prev [2];
    exp_t           e;

    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (rst_n) begin
                if (wr_a[s] != '0) begin
                    check("wr_pulse_width", 32'(wr_prev[s]), 32'h0);
                    if (sb.size() == 0 || sb[0].is_rd || sb[0].dut != s) begin
                        check("wr_unexpected", 32'(wr_a[s]), 32'h0);
                    end else begin
                        e = sb.pop_front();
                        check("wr_pulse_sel", 32'(wr_a[s]), 32'(16'(1) << e.idx));
                        check("wr_reg_val", 32'(rw_a[s][e.idx*DW +: DW]), 32'(e.data));
                    end
                end
                if (oe_a[s] && !oe_prev[s]) begin
                    if (sb.size() == 0 || !sb[0].is_rd || sb[0].dut != s) begin
                        check("rd_unexpected_oe", 32'(oe_a[s]), 32'h0);
                    end else begin
                        e = sb.pop_front();
                        check("rd_data", 32'(data_o_a[s]), 32'(e.data));
                        check("rd_pulse", 32'(rd_a[s]), 32'(e.rd_mask));
                    end
                end else if (rd_a[s] != '0) begin
                    check("rd_pulse_unexpected", 32'(rd_a[s]), 32'h0);
                end
            end
            wr_prev[s] = wr_a[s];
            oe_prev[s] = oe_a[s];
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_addr(input int s, input logic [15:0] a);
        data_i_a[s] = a;
        tick(1);
        as_a[s] = 1'b1;
        tick(4);
        as_a[s] = 1'b0;
        tick(4);
    endtask

    // exp_idx < 0 means the write must be rejected.
    task automatic bus_write(input int s, input logic [15:0] d, input int exp_idx);
        nrdwr_a[s]  = 1'b1;
        data_i_a[s] = d;
        tick(1);
        if (exp_idx >= 0)
            sb.push_back('{dut: s, is_rd: 1'b0, idx: exp_idx, data: d, rd_mask: 4'b0});
        ds_a[s] = 1'b1;
        tick(2);
        check("wr_latency_early", 32'(|wr_a[s]), 32'h0);
        tick(1);
        check("wr_latency", 32'(|wr_a[s]), 32'(exp_idx >= 0));
        tick(3);
        ds_a[s] = 1'b0;
        tick(5);
    endtask

    task automatic bus_read(input int s, input logic [15:0] exp_d, input logic [3:0] mask,
                            input bit poke);
        nrdwr_a[s] = 1'b0;
        tick(1);
        sb.push_back('{dut: s, is_rd: 1'b1, idx: 0, data: exp_d, rd_mask: mask});
        ds_a[s] = 1'b1;
        tick(2);
        check("rd_oe_early", 32'(oe_a[s]), 32'h0);
        tick(1);
        check("rd_oe", 32'(oe_a[s]), 32'h1);
        if (poke) begin
            ro_a[s][15:0] = ~ro_a[s][15:0];
            tick(2);
            check("rd_hold", 32'(data_o_a[s]), 32'(exp_d));
            ro_a[s][15:0] = ~ro_a[s][15:0];
            tick(1);
        end else begin
            tick(3);
        end
        ds_a[s] = 1'b0;
        tick(2);
        check("oe_before_drop", 32'(oe_a[s]), 32'h1);
        tick(1);
        check("oe_drop", 32'(oe_a[s]), 32'h0);
        tick(2);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            data_i_a[s] = '0;
            as_a[s]     = 1'b0;
            ds_a[s]     = 1'b0;
            nrdwr_a[s]  = 1'b0;
            wr_prev[s]  = '0;
            oe_prev[s]  = 1'b0;
        end
        ro_a[0] = {16'h4444, 16'h3333, 16'h2222, 16'h1234};
        ro_a[1] = '0;
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Reset state
        for (int i = 0; i < NRW; i++)
            check_reg(0, i, (i == REG_MODE) ? 16'h6700 : 16'h0000);
        check("reset_oe", 32'(oe_a[0]), 32'h0);
        check("reset_err", 32'(err_a[0]), 32'h0);
        check("reset_data_o", 32'(data_o_a[0]), 32'h0);
        check("reset_err1", 32'(err_a[1]), 32'h0);
        check_reg(1, 0, 16'h0000);

        // Plain write
        bus_addr(0, 16'(REG_WF_DATA));
        bus_write(0, 16'hA5A5, REG_WF_DATA);
        check_reg(0, REG_WF_DATA, 16'hA5A5);
        check("err_after_good_write", 32'(err_a[0]), 32'h0);

        // Reads: read-only window, window top, unmapped, read/write registers
        bus_addr(0, 16'(REG_ADC));
        bus_read(0, 16'h1234, 4'b0001, 1'b1);
        bus_addr(0, 16'd19);
        bus_read(0, 16'h4444, 4'b1000, 1'b0);
        bus_addr(0, 16'd25);
        bus_read(0, 16'h0000, 4'b0000, 1'b0);
        bus_addr(0, 16'(REG_MODE));
        bus_read(0, 16'h6700, 4'b0000, 1'b0);
        bus_addr(0, 16'(REG_WF_DATA));
        bus_read(0, 16'hA5A5, 4'b0000, 1'b0);

        // Write to read-only address sets sticky err; later writes still land
        bus_addr(0, 16'd17);
        bus_write(0, 16'h5555, -1);
        check("err_set", 32'(err_a[0]), 32'h1);
        check_reg(0, REG_WF_DATA, 16'hA5A5);
        check_reg(0, REG_MODE, 16'h6700);
        bus_addr(0, 16'(REG_OFFS));
        bus_write(0, 16'hBEEF, REG_OFFS);
        check("err_sticky", 32'(err_a[0]), 32'h1);
        check_reg(0, REG_OFFS, 16'hBEEF);
        bus_write(0, 16'hC0DE, REG_OFFS);
        check_reg(0, REG_OFFS, 16'hC0DE);
        check_reg(0, REG_AMPL, 16'h0000);

        // Auto-increment with wrap from 31 to 0
        bus_addr(1, 16'd30);
        bus_write(1, 16'h1111, -1);
        check("ai_err_set", 32'(err_a[1]), 32'h1);
        bus_write(1, 16'h2222, -1);
        bus_write(1, 16'h3333, 0);
        bus_write(1, 16'h4444, 1);
        check_reg(1, 0, 16'h3333);
        check_reg(1, 1, 16'h4444);
        check_reg(1, 2, 16'h0000);
        bus_addr(1, 16'd0);
        bus_read(1, 16'h3333, 4'b0000, 1'b0);
        bus_read(1, 16'h4444, 4'b0000, 1'b0);

        // Reset asserted mid-read, released with DS still high
        bus_addr(0, 16'(REG_ADC));
        nrdwr_a[0] = 1'b0;
        tick(1);
        sb.push_back('{dut: 0, is_rd: 1'b1, idx: 0, data: 16'h1234, rd_mask: 4'b0001});
        ds_a[0] = 1'b1;
        tick(4);
        check("pre_reset_oe", 32'(oe_a[0]), 32'h1);
        rst_n = 1'b0;
        #1;
        check("async_reset_oe", 32'(oe_a[0]), 32'h0);
        check("async_reset_data_o", 32'(data_o_a[0]), 32'h0);
        tick(2);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check("no_read_after_reset", {30'h0, oe_a[0], |rd_a[0]}, 32'h0);
        end
        ds_a[0] = 1'b0;
        tick(6);
        check("oe_after_release", 32'(oe_a[0]), 32'h0);
        check_reg(0, REG_MODE, 16'h6700);
        check_reg(0, REG_WF_DATA, 16'h0000);
        check("err_cleared0", 32'(err_a[0]), 32'h0);
        check("err_cleared1", 32'(err_a[1]), 32'h0);
        check_reg(1, 0, 16'h0000);

        // Bounded drain of outstanding expectations
        for (int i = 0; i < 50 && sb.size() != 0; i++) tick(1);
        check("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
